reg_file_mp: RTL and testbench

Parametrised successor to the 8x8 processor register file: 2 async read ports, 1 sync write port. Adds write-to-read forwarding, an optional hardwired-zero R0, and a sequential bulk-clear engine with busy/reject status. Sits in the CPU datapath between decode (addresses, WRITE) and ALU (OUT1/OUT2); the control unit drives CLEAR_REQ on context flush.

---
 rtl/reg_file_mp.sv | 103 ++++++++++
 tb/tb_reg_file_mp.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/reg_file_mp.sv
// rtl/reg_file_mp.sv - parametrised 2-read/1-write register file with forwarding and bulk clear
module reg_file_mp #(
    parameter int DATA_W   = 8,
    parameter int NUM_REGS = 8,
    parameter int ADDR_W   = 3,
    parameter int FORWARD  = 1,
    parameter int ZERO_REG = 0
) (
    input  logic                     CLK,
    input  logic                     RESET,
    input  logic signed [DATA_W-1:0] IN,
    input  logic        [ADDR_W-1:0] INADDRESS,
    input  logic                     WRITE,
    input  logic        [ADDR_W-1:0] OUT1ADDRESS,
    input  logic        [ADDR_W-1:0] OUT2ADDRESS,
    input  logic                     CLEAR_REQ,
    output logic signed [DATA_W-1:0] OUT1,
    output logic signed [DATA_W-1:0] OUT2,
    output logic                     BUSY,
    output logic                     WR_REJECT
);

    typedef enum logic {S_IDLE, S_CLEAR} state_t;

    localparam logic [ADDR_W:0] LP_NUM  = (ADDR_W+1)'(NUM_REGS);
    localparam logic [ADDR_W:0] LP_LAST = (ADDR_W+1)'(NUM_REGS - 1);

    state_t                    r_state;
    state_t                    w_next_state;
    logic        [ADDR_W:0]    r_ptr;
    logic        [ADDR_W:0]    w_next_ptr;
    logic signed [DATA_W-1:0]  r_regs [NUM_REGS];
    logic                      r_wr_reject;
    logic                      w_wr_valid;

    // An address is live if it maps to a real register that is not the hardwired zero.
    function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
        return ({1'b0, a} < LP_NUM) && !((ZERO_REG != 0) && (a == '0));
    endfunction

    assign w_wr_valid = (r_state == S_IDLE) && WRITE && addr_ok(INADDRESS);
    assign BUSY       = (r_state == S_CLEAR);
    assign WR_REJECT  = r_wr_reject;

    always_comb begin
        w_next_state = r_state;
        w_next_ptr   = '0;
        case (r_state)
            S_IDLE: begin
                if (CLEAR_REQ) begin
                    w_next_state = S_CLEAR;
                end
            end
            S_CLEAR: begin
                if (r_ptr == LP_LAST) begin
                    w_next_state = S_IDLE;
                end else begin
                    w_next_ptr = r_ptr + 1'b1;
                end
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_state     <= S_IDLE;
            r_ptr       <= '0;
            r_wr_reject <= 1'b0;
            for (int i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= '0;
            end
        end else begin
            r_state     <= w_next_state;
            r_ptr       <= w_next_ptr;
            r_wr_reject <= (r_state == S_CLEAR) && WRITE;
            if (r_state == S_CLEAR) begin
                r_regs[r_ptr[ADDR_W-1:0]] <= '0;
            end else if (w_wr_valid) begin
                r_regs[INADDRESS] <= IN;
            end
        end
    end

    // Bypass only applies to writes that will actually commit at the coming edge.
    always_comb begin
        OUT1 = '0;
        OUT2 = '0;
        if (addr_ok(OUT1ADDRESS)) begin
            OUT1 = r_regs[OUT1ADDRESS];
        end
        if (addr_ok(OUT2ADDRESS)) begin
            OUT2 = r_regs[OUT2ADDRESS];
        end
        if ((FORWARD != 0) && w_wr_valid && (OUT1ADDRESS == INADDRESS)) begin
            OUT1 = IN;
        end
        if ((FORWARD != 0) && w_wr_valid && (OUT2ADDRESS == INADDRESS)) begin
            OUT2 = IN;
        end
    end

endmodule

// File: tb/tb_reg_file_mp.sv
// tb/tb_reg_file_mp.sv - scoreboard bench for reg_file_mp in two parameterisations
module tb_reg_file_mp;

    logic clk;

    logic       a_rst_n, a_write, a_clr;
    logic [7:0] a_in;
    logic [2:0] a_ia, a_o1a, a_o2a;
    logic [7:0] a_out1, a_out2;
    logic       a_busy, a_rej;

    logic       b_rst_n, b_write, b_clr;
    logic [7:0] b_in;
    logic [2:0] b_ia, b_o1a, b_o2a;
    logic [7:0] b_out1, b_out2;
    logic       b_busy, b_rej;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        int         sig;
        logic [7:0] val;
        string      nm;
    } exp_t;
    exp_t exp_q[$];

    reg_file_mp #(.DATA_W(8), .NUM_REGS(8), .ADDR_W(3), .FORWARD(1), .ZERO_REG(0)) u_a (
        .CLK(clk), .RESET(a_rst_n), .IN(a_in), .INADDRESS(a_ia), .WRITE(a_write),
        .OUT1ADDRESS(a_o1a), .OUT2ADDRESS(a_o2a), .CLEAR_REQ(a_clr),
        .OUT1(a_out1), .OUT2(a_out2), .BUSY(a_busy), .WR_REJECT(a_rej)
    );

    reg_file_mp #(.DATA_W(8), .NUM_REGS(6), .ADDR_W(3), .FORWARD(0), .ZERO_REG(1)) u_b (
        .CLK(clk), .RESET(b_rst_n), .IN(b_in), .INADDRESS(b_ia), .WRITE(b_write),
        .OUT1ADDRESS(b_o1a), .OUT2ADDRESS(b_o2a), .CLEAR_REQ(b_clr),
        .OUT1(b_out1), .OUT2(b_out2), .BUSY(b_busy), .WR_REJECT(b_rej)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Signal ids: 0..3 = A out1/out2/busy/reject, 4..7 = same for B.
    task automatic chk(input int sig, input logic [7:0] v, input string nm);
        exp_t e;
        e.sig = sig;
        e.val = v;
        e.nm  = nm;
        exp_q.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        while (exp_q.size() > 0) begin
            exp_t       e;
            logic [7:0] got;
            e = exp_q.pop_front();
            case (e.sig)
                0:       got = a_out1;
                1:       got = a_out2;
                2:       got = {7'd0, a_busy};
                3:       got = {7'd0, a_rej};
                4:       got = b_out1;
                5:       got = b_out2;
                6:       got = {7'd0, b_busy};
                default: got = {7'd0, b_rej};
            endcase
            n_checks++;
            if (got !== e.val) begin
                n_fail++;
                $display("FAIL %s: got %02h expected %02h at %0t", e.nm, got, e.val, $time);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        a_rst_n = 0; a_write = 0; a_clr = 0; a_in = 0; a_ia = 0; a_o1a = 3; a_o2a = 7;
        b_rst_n = 0; b_write = 0; b_clr = 0; b_in = 0; b_ia = 0; b_o1a = 0; b_o2a = 0;

        tick();
        chk(0, 8'h00, "reset_out1"); chk(1, 8'h00, "reset_out2");
        chk(2, 8'h00, "reset_busy"); chk(3, 8'h00, "reset_rej");
        chk(6, 8'h00, "b_reset_busy");
        a_rst_n = 1; b_rst_n = 1;

        // Basic write then read
        tick(); a_write = 1; a_ia = 3; a_in = 8'h5A; a_o1a = 0; a_o2a = 7;
        tick(); a_write = 0; a_o1a = 3; a_o2a = 7;
        chk(0, 8'h5A, "t1_r3"); chk(1, 8'h00, "t1_r7");

        // Forwarding on both ports
        tick(); a_write = 1; a_ia = 2; a_in = 8'h11;
        tick(); a_in = 8'hF0; a_o1a = 2; a_o2a = 2;
        chk(0, 8'hF0, "t2_fwd1"); chk(1, 8'hF0, "t2_fwd2");
        tick(); a_write = 0;
        chk(0, 8'hF0, "t2_post1"); chk(1, 8'hF0, "t2_post2");

        // Fill 1..8 then clear, checking progressive clearing
        for (int i = 0; i < 8; i++) begin
            tick(); a_write = 1; a_ia = i[2:0]; a_in = 8'(i + 1);
        end
        tick(); a_write = 0; a_clr = 1; a_o1a = 7;
        chk(0, 8'h08, "t3_r7_filled"); chk(2, 8'h00, "t3_busy_pre");
        for (int k = 0; k < 8; k++) begin
            tick(); a_clr = 0; a_o1a = k[2:0];
            a_o2a = (k == 0) ? 3'd7 : 3'(k - 1);
            chk(2, 8'h01, $sformatf("t3_busy_k%0d", k));
            chk(0, 8'(k + 1), $sformatf("t3_uncleared_k%0d", k));
            chk(1, (k == 0) ? 8'h08 : 8'h00, $sformatf("t3_cleared_k%0d", k));
        end
        for (int j = 0; j < 4; j++) begin
            tick(); a_o1a = 3'(2 * j); a_o2a = 3'(2 * j + 1);
            chk(2, 8'h00, $sformatf("t3_busy_done%0d", j));
            chk(0, 8'h00, $sformatf("t3_zero_r%0d", 2 * j));
            chk(1, 8'h00, $sformatf("t3_zero_r%0d", 2 * j + 1));
        end

        // Rejected writes and ignored re-request during clear
        tick(); a_write = 1; a_ia = 5; a_in = 8'h33;
        tick(); a_write = 0; a_clr = 1;
        for (int k = 0; k < 8; k++) begin
            tick(); a_clr = (k == 4); a_write = (k == 2 || k == 5 || k == 6);
            a_ia = 5; a_in = 8'h77; a_o1a = 5;
            chk(2, 8'h01, $sformatf("t4_busy_k%0d", k));
            chk(3, (k == 3 || k == 6 || k == 7) ? 8'h01 : 8'h00, $sformatf("t4_rej_k%0d", k));
            chk(0, (k <= 5) ? 8'h33 : 8'h00, $sformatf("t4_r5_k%0d", k));
        end
        tick(); a_write = 0; a_clr = 0;
        chk(2, 8'h00, "t4_busy_end"); chk(3, 8'h00, "t4_rej_end"); chk(0, 8'h00, "t4_r5_end");
        tick();
        chk(2, 8'h00, "t4_no_restart");

        // Second parameterisation: no forwarding, hardwired R0, six registers
        tick(); b_write = 1; b_ia = 1; b_in = 8'h11;
        tick(); b_in = 8'hF0; b_o1a = 1; b_o2a = 1;
        chk(4, 8'h11, "b_nofwd1"); chk(5, 8'h11, "b_nofwd2");
        tick(); b_ia = 0; b_in = 8'hFF; b_o1a = 0;
        chk(4, 8'h00, "b_r0_fwd"); chk(5, 8'hF0, "b_r1_stored");
        tick(); b_ia = 7; b_in = 8'hAA; b_o2a = 7;
        chk(4, 8'h00, "b_r0_read"); chk(7, 8'h00, "b_r0_norej");
        tick(); b_ia = 6; b_in = 8'hBB; b_o1a = 6;
        chk(5, 8'h00, "b_addr7");
        tick(); b_ia = 5; b_in = 8'h5C; b_o2a = 7;
        chk(4, 8'h00, "b_addr6"); chk(5, 8'h00, "b_addr7_after"); chk(7, 8'h00, "b_oob_norej");
        tick(); b_write = 0; b_clr = 1; b_o1a = 5; b_o2a = 1;
        chk(4, 8'h5C, "b_r5_last");
        for (int k = 0; k < 6; k++) begin
            tick(); b_clr = 0;
            chk(6, 8'h01, $sformatf("b_busy_k%0d", k));
            chk(4, 8'h5C, $sformatf("b_r5_k%0d", k));
            chk(5, (k <= 1) ? 8'hF0 : 8'h00, $sformatf("b_r1_k%0d", k));
        end
        tick();
        chk(6, 8'h00, "b_busy_end"); chk(4, 8'h00, "b_r5_cleared");

        // Write with clear request, then async reset mid-clear
        tick(); a_write = 1; a_ia = 6; a_in = 8'h80;
        tick(); a_ia = 7; a_in = 8'h99; a_clr = 1; a_o1a = 7; a_o2a = 6;
        chk(0, 8'h99, "t6_fwd_with_clr"); chk(1, 8'h80, "t6_r6");
        for (int k = 0; k < 3; k++) begin
            tick(); a_clr = 0; a_write = (k == 2); a_ia = 1; a_in = 8'h55;
            chk(0, 8'h99, $sformatf("t6_r7_k%0d", k)); chk(1, 8'h80, $sformatf("t6_r6_k%0d", k));
            chk(2, 8'h01, $sformatf("t6_busy_k%0d", k));
        end
        tick(); a_rst_n = 0; a_write = 0;
        #1;
        chk(0, 8'h00, "t6_rst_r7"); chk(1, 8'h00, "t6_rst_r6");
        chk(2, 8'h00, "t6_rst_busy"); chk(3, 8'h00, "t6_rst_rej");
        tick(); a_rst_n = 1; a_write = 1; a_ia = 6; a_in = 8'h42;
        tick(); a_write = 0;
        chk(1, 8'h42, "t6_post_write"); chk(2, 8'h00, "t6_post_busy");

        tick();
        tick();
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
